shift_seq8: RTL and testbench



---
 rtl/shift_seq8.sv | 131 +++++++++++++
 tb/tb_shift_seq8.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shift sequencer: applies a 0..3-position shifter stage
// iteratively until the requested 0..15 amount is consumed, then pulses done.
module shift_seq8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] amt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned OPW = 2;

  localparam logic [OPW-1:0] OP_LSL = 2'b00;
  localparam logic [OPW-1:0] OP_LSR = 2'b01;
  localparam logic [OPW-1:0] OP_ASR = 2'b10;
  localparam logic [OPW-1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_acc;
  logic [AW-1:0]   r_rem;
  logic [OPW-1:0]  r_op;
  logic [DW-1:0]   r_d_out;
  logic            r_busy;
  logic            r_done;

  logic [1:0]      w_step;
  logic [AW-1:0]   w_rem_nxt;
  logic [DW-1:0]   w_shifted;
  logic [2*DW-1:0] w_rot;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  // Per-pass step is the remaining amount clamped to the stage's 3-position limit
  always_comb begin
    w_step    = (r_rem > AW'(3)) ? 2'd3 : r_rem[1:0];
    w_rem_nxt = r_rem - AW'(w_step);
  end

  // Single shifter stage
  always_comb begin
    w_shifted = r_acc;
    w_rot     = {r_acc, r_acc} >> w_step;
    case (r_op)
      OP_LSL:  w_shifted = r_acc << w_step;
      OP_LSR:  w_shifted = r_acc >> w_step;
      OP_ASR:  w_shifted = DW'($signed(r_acc) >>> w_step);
      OP_ROR:  w_shifted = w_rot[DW-1:0];
      default: w_shifted = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (amt == AW'(0)) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_rem_nxt == AW'(0)) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with the state register
  always_comb begin
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Datapath: operands captured only on accept; result captured on entry to DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_rem   <= '0;
      r_op    <= '0;
      r_d_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc <= d_in;
            r_rem <= amt;
            r_op  <= op;
            if (amt == AW'(0)) r_d_out <= d_in;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == AW'(0)) r_d_out <= w_shifted;
        end
        default: ;
      endcase
    end
  end

  assign d_out = r_d_out;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: directed scenarios plus randomized
// requests checked against an arithmetic reference of the whole shift.
module tb_shift_seq8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] amt = 4'd0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  shift_seq8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .d_in    (d_in),
    .d_out   (d_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Whole-amount reference: the sequence of passes must equal one shift by amt
  function automatic logic [7:0] ref_shift(input logic [1:0] o, input int a, input logic [7:0] d);
    logic [15:0] dd;
    logic [7:0]  r;
    dd = {d, d};
    case (o)
      2'b00:   r = (a >= 8) ? 8'h00 : 8'(d << a);
      2'b01:   r = (a >= 8) ? 8'h00 : 8'(d >> a);
      2'b10:   r = (a >= 8) ? {8{d[7]}} : 8'($signed(d) >>> a);
      default: r = 8'(dd >> (a % 8));
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] exp_dout);
    chk({tag, "_busy"}, 8'(busy), 8'h00);
    chk({tag, "_done"}, 8'(done), 8'h00);
    chk({tag, "_dout"}, d_out, exp_dout);
  endtask

  // Caller is at a negedge in IDLE; returns at the negedge of the cycle after DONE
  task automatic run_op(input string tag, input logic [1:0] o, input int a,
                        input logic [7:0] d, input bit inject, output logic [7:0] res);
    int n;
    res = ref_shift(o, a, d);
    n   = (a + 2) / 3;
    start = 1'b1; op = o; amt = 4'(a); d_in = d;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); amt = 4'($urandom); d_in = 8'($urandom);
    for (int k = 1; k <= n + 1; k++) begin
      chk({tag, "_busy"}, 8'(busy), 8'h01);
      chk({tag, "_done"}, 8'(done), (k == n + 1) ? 8'h01 : 8'h00);
      if (k == n + 1) chk({tag, "_dout"}, d_out, res);
      start = inject ? 1'($urandom) : 1'b0;
      op = 2'($urandom); amt = 4'($urandom); d_in = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk_idle({tag, "_post"}, res);
  endtask

  logic [7:0] res;
  logic [7:0] last;

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); op = 2'($urandom); amt = 4'($urandom); d_in = 8'($urandom);
      @(negedge clk);
      chk_idle("rst_hold", 8'h00);
    end
    start = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("rst_idle", 8'h00);
    end

    run_op("lsr2",  2'b01, 2,  8'hB4, 1'b0, res); chk("lsr2_val", res, 8'h2D);
    run_op("asr7n", 2'b10, 7,  8'h80, 1'b0, res); chk("asr7n_val", res, 8'hFF);
    run_op("asr7p", 2'b10, 7,  8'h7F, 1'b0, res); chk("asr7p_val", res, 8'h00);
    run_op("lsl0",  2'b00, 0,  8'h5A, 1'b0, res); chk("lsl0_val", res, 8'h5A);
    run_op("lsl9",  2'b00, 9,  8'hFF, 1'b0, res); chk("lsl9_val", res, 8'h00);
    @(negedge clk);
    run_op("ror10", 2'b11, 10, 8'h01, 1'b1, res); chk("ror10_val", res, 8'h40);
    last = res;

    // Reset in the 3rd SHIFT cycle of ASR by 15
    start = 1'b1; op = 2'b10; amt = 4'd15; d_in = 8'h81;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy1", 8'(busy), 8'h01);
    @(negedge clk);
    @(negedge clk);
    chk("mid_done3", 8'(done), 8'h00);
    chk("mid_dout3", d_out, last);
    #2 reset_n = 1'b0;
    #1;
    chk_idle("mid_async", 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_idle("mid_after", 8'h00);
    end
    run_op("lsl1", 2'b00, 1, 8'h81, 1'b0, res); chk("lsl1_val", res, 8'h02);

    // Randomized requests, some back-to-back, some with ignored start pulses
    for (int i = 0; i < 60; i++) begin
      logic [1:0] ro;
      int         ra;
      logic [7:0] rd;
      ro = 2'($urandom);
      ra = int'($urandom_range(0, 15));
      rd = 8'($urandom);
      run_op("rand", ro, ra, rd, 1'($urandom), res);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk_idle("rand_gap", res);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
